// File: rtl/msrv32_pkg.sv
// Shared types and limits for the msrv32 register file.
// Purely declarative; no logic and no latency.
package msrv32_pkg;

    localparam int RF_XLEN   = 32;
    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_WR = 2;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/msrv32_regfile_clear_fsm.sv
// Sequenced clear engine: after reset or clear_req, zeroes one register per cycle for NUM_REGS cycles.
// ready is registered; clear_req is ignored once a clear is already running.
module msrv32_regfile_clear_fsm
    import msrv32_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk_in,
    input  logic          reset_n_in,
    input  logic          clear_req_in,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clear_req_in) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
            RF_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NUM_REGS - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
        ready_d = (state_d == RF_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = clr_idx_q;

endmodule

// File: rtl/msrv32_regfile_mp.sv
// Multi-port register file with same-cycle write forwarding, busy scoreboard and sequenced clear.
// Reads are combinational; writes store at the next edge. While clearing, reads return 0 and writes/issues are dropped.
module msrv32_regfile_mp
    import msrv32_pkg::*;
#(
    parameter  int XLEN     = RF_XLEN,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic [NUM_RD*AW-1:0]   rs_addr_in,
    output logic [NUM_RD*XLEN-1:0] rs_data_out,
    output logic [NUM_RD-1:0]      rs_busy_out,
    input  logic [NUM_WR-1:0]      wr_en_in,
    input  logic [NUM_WR*AW-1:0]   wr_addr_in,
    input  logic [NUM_WR*XLEN-1:0] wr_data_in,
    input  logic                   issue_en_in,
    input  logic [AW-1:0]          issue_addr_in,
    input  logic                   clear_req_in,
    output logic                   ready_out
);

    logic          ready;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    msrv32_regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .clear_req_in (clear_req_in),
        .ready        (ready),
        .clr_we       (clr_we),
        .clr_addr     (clr_addr)
    );

    assign ready_out = ready;

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_WR-1:0]   wr_act;

    // A write only takes effect when the file is usable and it does not target a hardwired x0.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_act[w] = ready && wr_en_in[w] &&
                        !(ZERO_REG && (wr_addr_in[w*AW +: AW] == '0));
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w]) begin
                    regs_d[wr_addr_in[w*AW +: AW]] = wr_data_in[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        regs_q <= regs_d;
    end

    // Issue is applied after write-clears so a same-cycle reissue leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (!ready || clear_req_in) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w]) begin
                    busy_d[wr_addr_in[w*AW +: AW]] = 1'b0;
                end
            end
            if (issue_en_in && !(ZERO_REG && (issue_addr_in == '0))) begin
                busy_d[issue_addr_in] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_fwd;
        logic            rd_hit;
        logic [XLEN-1:0] rd_dat;
        logic            rd_busy;

        assign rd_addr = rs_addr_in[p*AW +: AW];

        always_comb begin
            rd_hit = 1'b0;
            rd_fwd = regs_q[rd_addr];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w] && (wr_addr_in[w*AW +: AW] == rd_addr)) begin
                    rd_hit = 1'b1;
                    rd_fwd = wr_data_in[w*XLEN +: XLEN];
                end
            end
            if (!ready || (ZERO_REG && (rd_addr == '0))) begin
                rd_dat  = '0;
                rd_busy = 1'b0;
            end else begin
                rd_dat  = rd_fwd;
                rd_busy = busy_q[rd_addr] & ~rd_hit;
            end
        end

        assign rs_data_out[p*XLEN +: XLEN] = rd_dat;
        assign rs_busy_out[p]              = rd_busy;
    end

endmodule

// File: tb/tb_msrv32_regfile_mp.sv
// Directed bench for msrv32_regfile_mp with a queue-based scoreboard.
module tb_msrv32_regfile_mp;

    localparam int KD = 0;
    localparam int KB = 1;
    localparam int KR = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        clear_req;
    logic        ready;

    always #5 clk = ~clk;

    msrv32_regfile_mp dut (
        .clk_in        (clk),
        .reset_n_in    (rst_n),
        .rs_addr_in    (rs_addr),
        .rs_data_out   (rs_data),
        .rs_busy_out   (rs_busy),
        .wr_en_in      (wr_en),
        .wr_addr_in    (wr_addr),
        .wr_data_in    (wr_data),
        .issue_en_in   (issue_en),
        .issue_addr_in (issue_addr),
        .clear_req_in  (clear_req),
        .ready_out     (ready)
    );

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int kind, input int port, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: inputs settle at posedge+1, outputs are compared at the following negedge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    KD:      act = rs_data[e.port*32 +: 32];
                    KB:      act = {31'b0, rs_busy[e.port]};
                    default: act = {31'b0, ready};
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.val, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rs_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        clear_req  = 1'b0;
    endtask

    // Called right after reset release or clear start: ready must stay low for exactly 32 edges.
    task automatic ready_seq(input string name);
        push(KR, 0, 32'd0, name);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            push(KR, 0, (k == 32) ? 32'd1 : 32'd0, name);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rs_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        clear_req  = 1'b0;

        // Reset and initial clear
        repeat (3) @(posedge clk);
        #1;
        push(KR, 0, 32'd0, "rst_ready");
        push(KB, 0, 32'd0, "rst_busy");
        rst_n = 1'b1;
        ready_seq("init_ready");
        for (int i = 0; i < 16; i++) begin
            step();
            rs_addr = {5'(2*i + 1), 5'(2*i)};
            push(KD, 0, 32'd0, "init_zero");
            push(KD, 1, 32'd0, "init_zero");
            push(KB, 0, 32'd0, "init_busy");
            push(KB, 1, 32'd0, "init_busy");
        end

        // Forwarding then storage
        step();
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEAD_BEEF; rs_addr[4:0] = 5'd5;
        push(KD, 0, 32'hDEAD_BEEF, "fwd_same_cycle");
        step();
        rs_addr[4:0] = 5'd5;
        push(KD, 0, 32'hDEAD_BEEF, "x5_stored");

        // Dual write to one address: port 1 wins; x0 stays zero
        step();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111};
        rs_addr = {5'd5, 5'd7};
        push(KD, 0, 32'h2222, "wr_priority_fwd");
        push(KD, 1, 32'hDEAD_BEEF, "x5_hold");
        step();
        rs_addr[4:0] = 5'd7;
        push(KD, 0, 32'h2222, "wr_priority_stored");
        step();
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF; rs_addr[4:0] = 5'd0;
        push(KD, 0, 32'd0, "x0_fwd");
        step();
        rs_addr[4:0] = 5'd0;
        push(KD, 0, 32'd0, "x0_stored");

        // Scoreboard
        step();
        issue_en = 1'b1; issue_addr = 5'd9; rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd0, "issue_same_cycle");
        step();
        rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd1, "issue_busy");
        step();
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h42; rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd0, "wr_masks_busy");
        push(KD, 0, 32'h42, "wr_x9_fwd");
        step();
        rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd0, "busy_cleared");
        push(KD, 0, 32'h42, "x9_stored");
        step();
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h77; rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd0, "iss_wr_same_cycle");
        push(KD, 0, 32'h77, "iss_wr_fwd");
        step();
        rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd1, "issue_wins");
        step();
        issue_en = 1'b1; issue_addr = 5'd9; rs_addr[4:0] = 5'd9;
        push(KB, 0, 32'd1, "reissue_busy");
        step();
        issue_en = 1'b1; issue_addr = 5'd0; rs_addr = {5'd0, 5'd9};
        push(KB, 0, 32'd1, "reissue_keeps");
        step();
        rs_addr = {5'd0, 5'd9};
        push(KB, 1, 32'd0, "x0_never_busy");
        push(KB, 0, 32'd1, "x9_still_busy");

        // Clear request with writes and issues attempted during the clear
        step();
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h55;
        step();
        rs_addr = {5'd9, 5'd3}; clear_req = 1'b1;
        push(KD, 0, 32'h55, "x3_set");
        push(KB, 1, 32'd1, "x9_busy_pre");
        push(KR, 0, 32'd1, "clr_req_cycle");
        for (int k = 1; k <= 32; k++) begin
            step();
            wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'hAA;
            issue_en = 1'b1; issue_addr = 5'd4;
            rs_addr = {5'd9, 5'd3};
            if (k == 5) clear_req = 1'b1;
            push(KR, 0, 32'd0, "clearing_ready");
            if (k == 1 || k == 32) begin
                push(KD, 0, 32'd0, "clr_rd_zero");
                push(KB, 1, 32'd0, "clr_busy_zero");
            end
        end
        step();
        rs_addr = {5'd9, 5'd3};
        push(KR, 0, 32'd1, "clr_done");
        push(KD, 0, 32'd0, "x3_cleared");
        push(KB, 1, 32'd0, "x9_busy_cleared");
        step();
        rs_addr = {5'd3, 5'd4};
        push(KB, 0, 32'd0, "x4_not_busy");
        push(KD, 1, 32'd0, "x3_not_written");

        // Reset in the middle of a clear restarts it from index 0
        step();
        wr_en = 2'b01; wr_addr[4:0] = 5'd12; wr_data[31:0] = 32'h1234; clear_req = 1'b1;
        push(KR, 0, 32'd1, "clr2_req_cycle");
        for (int k = 1; k <= 10; k++) begin
            step();
            push(KR, 0, 32'd0, "clr2_ready");
        end
        rst_n = 1'b0;
        step();
        push(KR, 0, 32'd0, "rst_mid_ready");
        rst_n = 1'b1;
        ready_seq("restart_ready");
        step();
        rs_addr = {5'd7, 5'd12};
        push(KD, 0, 32'd0, "x12_cleared");
        push(KD, 1, 32'd0, "x7_cleared");

        step();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
